// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the UART boot loader: FSM states, error codes
// and the default frame header byte.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/boot_timeout_timer.sv
// Inter-byte gap timer: counts idle cycles while run is high and pulses expired
// for one cycle when the gap reaches TIMEOUT_CYCLES.
module boot_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] gap_cnt;

    always_ff @(posedge clk) begin
        if (srst || clear || !run) begin
            gap_cnt <= '0;
        end else if (gap_cnt != CW'(TIMEOUT_CYCLES)) begin
            gap_cnt <= gap_cnt + CW'(1);
        end
    end

    // Fires in the cycle that completes the gap; a byte in that cycle (clear) wins.
    assign expired = run & ~clear & (gap_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_boot_loader.sv
// Parses a boot frame from the UART receiver, packs little-endian words into
// instruction memory and releases the CPU once the payload checksum matches.
module uart_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                MAX_WORDS      = 4096,
    parameter int                TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]        HEADER         = DEFAULT_HEADER
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              rx_enable,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              restart,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code
);

    state_t      state;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [7:0]  csum;
    logic [23:0] word_buf;
    logic        take;
    logic        run;
    logic        expired;

    assign rx_enable = rx_done & (state inside {IDLE, LEN0, LEN1, DATA, CSUM});
    assign take      = rx_done & rx_enable;
    assign run       = state inside {LEN0, LEN1, DATA, CSUM};

    boot_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .srst   (srst),
        .clear  (take),
        .run    (run),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            len       <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            csum      <= '0;
            word_buf  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (take && rx_data == HEADER) state <= LEN0;
                end
                LEN0: begin
                    if (take) begin
                        len[7:0] <= rx_data;
                        state    <= LEN1;
                    end
                end
                LEN1: begin
                    if (take) begin
                        len[15:8] <= rx_data;
                        if ({16'd0, rx_data, len[7:0]} > 32'(MAX_WORDS)) begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                            err_code <= ERR_LEN;
                        end else if ({rx_data, len[7:0]} == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (take) begin
                        csum     <= csum + rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    word_buf[7:0]   <= rx_data;
                            2'd1:    word_buf[15:8]  <= rx_data;
                            2'd2:    word_buf[23:16] <= rx_data;
                            default: begin
                                mem_we    <= 1'b1;
                                mem_wdata <= {rx_data, word_buf};
                                mem_addr  <= BASE_ADDR + ADDR_W'({word_idx, 2'b00});
                                word_idx  <= word_idx + 16'd1;
                                if (word_idx == len - 16'd1) state <= CSUM;
                            end
                        endcase
                    end
                end
                CSUM: begin
                    if (take) begin
                        if (rx_data == csum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            cpu_rst   <= 1'b0;
                        end else begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                    end
                end
                DONE, ERROR: begin
                    if (restart) begin
                        state     <= IDLE;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        err_code  <= ERR_NONE;
                        csum      <= '0;
                        word_idx  <= '0;
                        byte_cnt  <= '0;
                        cpu_rst   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Timer only runs in frame states and never fires alongside an accepted byte.
            if (expired) begin
                state    <= ERROR;
                load_err <= 1'b1;
                err_code <= ERR_TIMEOUT;
                cpu_rst  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed self-checking bench for uart_boot_loader with a 100-cycle byte timeout.
module tb_uart_boot_loader;

    logic        clk = 1'b0;
    logic        srst;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        rx_enable;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        restart;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;
    logic [1:0]  err_code;

    int checks = 0;
    int fails  = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    uart_boot_loader #(
        .ADDR_W        (32),
        .BASE_ADDR     (32'h0),
        .MAX_WORDS     (4096),
        .TIMEOUT_CYCLES(100),
        .HEADER        (8'hA5)
    ) dut (
        .clk      (clk),
        .srst     (srst),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .rx_enable(rx_enable),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .restart  (restart),
        .cpu_rst  (cpu_rst),
        .load_done(load_done),
        .load_err (load_err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        bit taken = 1'b0;
        rx_data = b;
        rx_done = 1'b1;
        #1;
        for (int n = 0; n < 50 && !taken; n++) begin
            if (rx_enable === 1'b1) taken = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_done = 1'b0;
        checks++;
        if (!taken) begin
            fails++;
            $display("FAIL rx_accept: byte %h not taken, rx_enable=%b required 1", b, rx_enable);
        end
    endtask

    task automatic send_seq(input logic [7:0] seq[$]);
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        checks++; if (cpu_rst !== 1'b1) begin fails++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
        checks++; if (load_done !== 1'b0) begin fails++; $display("FAIL rst_load_done: got %b want 0", load_done); end
        checks++; if (load_err !== 1'b0) begin fails++; $display("FAIL rst_load_err: got %b want 0", load_err); end
        checks++; if (err_code !== 2'd0) begin fails++; $display("FAIL rst_err_code: got %0d want 0", err_code); end
    endtask

    task automatic check_frame1_writes(input string tag);
        checks++; if (wr_addr_q.size() !== 2) begin fails++; $display("FAIL %s_nwrites: got %0d want 2", tag, wr_addr_q.size()); end
        checks++; if (wr_addr_q[0] !== 32'h0) begin fails++; $display("FAIL %s_addr0: got %h want 00000000", tag, wr_addr_q[0]); end
        checks++; if (wr_data_q[0] !== 32'h44332211) begin fails++; $display("FAIL %s_data0: got %h want 44332211", tag, wr_data_q[0]); end
        checks++; if (wr_addr_q[1] !== 32'h4) begin fails++; $display("FAIL %s_addr1: got %h want 00000004", tag, wr_addr_q[1]); end
        checks++; if (wr_data_q[1] !== 32'h88776655) begin fails++; $display("FAIL %s_data1: got %h want 88776655", tag, wr_data_q[1]); end
    endtask

    task automatic test_reset();
        srst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; restart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cpu_rst !== 1'b1) begin fails++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
        checks++; if (load_done !== 1'b0) begin fails++; $display("FAIL reset_load_done: got %b want 0", load_done); end
        checks++; if (load_err !== 1'b0) begin fails++; $display("FAIL reset_load_err: got %b want 0", load_err); end
        checks++; if (err_code !== 2'd0) begin fails++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
        checks++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        srst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame_ok();
        logic [7:0] f[$];
        f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        clear_writes();
        send_seq(f);
        settle();
        check_frame1_writes("ok");
        checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL ok_load_done: got %b want 1", load_done); end
        checks++; if (cpu_rst !== 1'b0) begin fails++; $display("FAIL ok_cpu_rst: got %b want 0", cpu_rst); end
        checks++; if (load_err !== 1'b0) begin fails++; $display("FAIL ok_load_err: got %b want 0", load_err); end
        do_restart();
    endtask

    task automatic test_bad_csum();
        logic [7:0] f[$];
        f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
        clear_writes();
        send_seq(f);
        settle();
        check_frame1_writes("csum");
        checks++; if (load_err !== 1'b1) begin fails++; $display("FAIL csum_load_err: got %b want 1", load_err); end
        checks++; if (err_code !== 2'd3) begin fails++; $display("FAIL csum_err_code: got %0d want 3", err_code); end
        checks++; if (cpu_rst !== 1'b1) begin fails++; $display("FAIL csum_cpu_rst: got %b want 1", cpu_rst); end
        checks++; if (load_done !== 1'b0) begin fails++; $display("FAIL csum_load_done: got %b want 0", load_done); end
        do_restart();
    endtask

    task automatic test_discard_empty();
        logic [7:0] f[$];
        f = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        clear_writes();
        send_seq(f);
        settle();
        checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL empty_load_done: got %b want 1", load_done); end
        checks++; if (cpu_rst !== 1'b0) begin fails++; $display("FAIL empty_cpu_rst: got %b want 0", cpu_rst); end
        checks++; if (wr_addr_q.size() !== 0) begin fails++; $display("FAIL empty_nwrites: got %0d want 0", wr_addr_q.size()); end
        do_restart();
    endtask

    task automatic test_bad_len();
        logic [7:0] f[$];
        f = '{8'hA5, 8'h01, 8'h10};
        clear_writes();
        send_seq(f);
        settle();
        checks++; if (load_err !== 1'b1) begin fails++; $display("FAIL len_load_err: got %b want 1", load_err); end
        checks++; if (err_code !== 2'd1) begin fails++; $display("FAIL len_err_code: got %0d want 1", err_code); end
        checks++; if (wr_addr_q.size() !== 0) begin fails++; $display("FAIL len_nwrites: got %0d want 0", wr_addr_q.size()); end
        rx_data = 8'hA5;
        rx_done = 1'b1;
        #1;
        checks++; if (rx_enable !== 1'b0) begin fails++; $display("FAIL len_rx_enable_in_error: got %b want 0", rx_enable); end
        rx_done = 1'b0;
        @(posedge clk);
        #1;
        do_restart();
    endtask

    task automatic test_timeout();
        logic [7:0] f[$];
        f = '{8'hA5, 8'h03, 8'h00, 8'hAA};
        send_seq(f);
        repeat (99) @(posedge clk);
        #1;
        checks++; if (load_err !== 1'b0) begin fails++; $display("FAIL tmo_early_load_err: got %b want 0 at gap 99", load_err); end
        @(posedge clk);
        #1;
        checks++; if (load_err !== 1'b1) begin fails++; $display("FAIL tmo_load_err: got %b want 1 at gap 100", load_err); end
        checks++; if (err_code !== 2'd2) begin fails++; $display("FAIL tmo_err_code: got %0d want 2", err_code); end
        checks++; if (cpu_rst !== 1'b1) begin fails++; $display("FAIL tmo_cpu_rst: got %b want 1", cpu_rst); end
        do_restart();
        f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        clear_writes();
        send_seq(f);
        settle();
        check_frame1_writes("tmo_reload");
        checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL tmo_reload_done: got %b want 1", load_done); end
        do_restart();
    endtask

    task automatic test_srst_mid_data();
        logic [7:0] f[$];
        f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        clear_writes();
        send_seq(f);
        settle();
        checks++; if (wr_addr_q.size() !== 1) begin fails++; $display("FAIL srst_pre_nwrites: got %0d want 1", wr_addr_q.size()); end
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        checks++; if (cpu_rst !== 1'b1) begin fails++; $display("FAIL srst_cpu_rst: got %b want 1", cpu_rst); end
        checks++; if (mem_we !== 1'b0) begin fails++; $display("FAIL srst_mem_we: got %b want 0", mem_we); end
        checks++; if (load_done !== 1'b0) begin fails++; $display("FAIL srst_load_done: got %b want 0", load_done); end
        clear_writes();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wr_addr_q.size() !== 0) begin fails++; $display("FAIL srst_post_nwrites: got %0d want 0", wr_addr_q.size()); end
        f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        send_seq(f);
        settle();
        check_frame1_writes("srst_reload");
        checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL srst_reload_done: got %b want 1", load_done); end
        checks++; if (cpu_rst !== 1'b0) begin fails++; $display("FAIL srst_reload_cpu_rst: got %b want 0", cpu_rst); end
    endtask

    initial begin
        test_reset();
        test_frame_ok();
        test_bad_csum();
        test_discard_empty();
        test_bad_len();
        test_timeout();
        test_srst_mid_data();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
